// File: rtl/alu_mdu_controller.sv
// ALU operation decoder plus IDLE/BUSY/DONE sequencer for a fixed-latency iterative MDU.
// Optional build macro ALU_MDU_DIVZERO_FAST_EN: single-cycle divide-by-zero completion with divzero_o.
module alu_mdu_controller #(
  parameter int ALU_OP_W    = 4,
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 33
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [1:0]          alu_ctrl_op_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  input  logic                rs2_zero_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                mdu_start_o,
  output logic [2:0]          mdu_op_o,
  output logic                mdu_abort_o,
  output logic                stall_o,
  output logic                result_sel_o,
`ifdef ALU_MDU_DIVZERO_FAST_EN
  output logic                divzero_o,
`endif
  output logic                busy_o
);

  // state  | meaning
  // S_IDLE | no MDU op in flight; issue check each cycle
  // S_BUSY | MDU iterating; counter holds remaining cycles minus one
  // S_DONE | MDU result valid, writeback selects it for one cycle
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    op_q, op_nxt;
  logic [3:0]    alu_op;
  logic          is_m;
  logic          fast;

  assign is_m = (alu_ctrl_op_i == 2'b10) && (funct7_i == 7'b0000001);

  always_comb begin
    alu_op = OP_ADD;
    if (alu_ctrl_op_i == 2'b01) begin
      alu_op = OP_SUB;
    end else if (alu_ctrl_op_i[1] && !is_m) begin
      unique case (funct3_i)
        3'd0:    alu_op = (alu_ctrl_op_i[0] == 1'b0 && funct7_i[5]) ? OP_SUB : OP_ADD;
        3'd1:    alu_op = OP_SLL;
        3'd2:    alu_op = OP_SLT;
        3'd3:    alu_op = OP_SLTU;
        3'd4:    alu_op = OP_XOR;
        3'd5:    alu_op = funct7_i[5] ? OP_SRA : OP_SRL;
        3'd6:    alu_op = OP_OR;
        default: alu_op = OP_AND;
      endcase
    end
  end

  assign alu_op_o = ALU_OP_W'(alu_op);

`ifdef ALU_MDU_DIVZERO_FAST_EN
  // The MDU already drives its div-by-zero constant, so no iteration is needed.
  assign fast      = (state == S_IDLE) && valid_i && is_m && funct3_i[2] && rs2_zero_i && !flush_i;
  assign divzero_o = fast;
`else
  logic unused_rs2_zero;
  assign unused_rs2_zero = rs2_zero_i;
  assign fast = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    op_nxt       = op_q;
    mdu_start_o  = 1'b0;
    mdu_abort_o  = 1'b0;
    stall_o      = 1'b0;
    result_sel_o = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fast) begin
          result_sel_o = 1'b1;
        end else if (valid_i && is_m && !flush_i) begin
          mdu_start_o = 1'b1;
          stall_o     = 1'b1;
          op_nxt      = funct3_i;
          cnt_nxt     = funct3_i[2] ? DIV_LOAD : MUL_LOAD;
          state_nxt   = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          mdu_abort_o = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_IDLE;
        end else if (cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        result_sel_o = !flush_i;
        cnt_nxt      = '0;
        state_nxt    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  assign mdu_op_o = op_q;
  assign busy_o   = (state == S_BUSY);

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Scoreboard bench for alu_mdu_controller: driver pushes expected per-cycle outputs from a
// timeline model of each MDU op; a negedge monitor pops and compares.
module tb_alu_mdu_controller;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       valid_i, flush_i, rs2_zero_i;
  logic [1:0] alu_ctrl_op_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic [3:0] alu_op_o;
  logic       mdu_start_o, mdu_abort_o, stall_o, result_sel_o, busy_o;
  logic [2:0] mdu_op_o;
`ifdef ALU_MDU_DIVZERO_FAST_EN
  logic       divzero_o;
`endif

  always #5 clk_i = ~clk_i;

  alu_mdu_controller #(.ALU_OP_W(4), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
    .alu_ctrl_op_i(alu_ctrl_op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rs2_zero_i(rs2_zero_i), .alu_op_o(alu_op_o), .mdu_start_o(mdu_start_o),
    .mdu_op_o(mdu_op_o), .mdu_abort_o(mdu_abort_o), .stall_o(stall_o),
    .result_sel_o(result_sel_o),
`ifdef ALU_MDU_DIVZERO_FAST_EN
    .divzero_o(divzero_o),
`endif
    .busy_o(busy_o));

  typedef struct packed {
    logic       chk_alu;
    logic [3:0] alu;
    logic       start;
    logic [2:0] op;
    logic       abort, stall, rsel, busy, divz;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: an op in flight is just its issue cycle and latency.
  bit         active = 0;
  int         t0 = 0, lat = 0, cyc = 0;
  logic [2:0] op_ref = 3'd0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [1:0] c, input logic [2:0] f3,
                                         input logic [6:0] f7);
    int tbl[8];
    tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (c == 2'd0) return 4'd0;
    if (c == 2'd1) return 4'd1;
    if (f3 == 3'd5 && f7[5]) return 4'd7;
    if (f3 == 3'd0 && c == 2'd2 && f7[5]) return 4'd1;
    return 4'(tbl[f3]);
  endfunction

  task automatic drive(input logic v, input logic fl, input logic [1:0] c, input logic [2:0] f3,
                       input logic [6:0] f7, input logic rz);
    exp_t e;
    bit   is_m, fast;
    int   ph;
    @(posedge clk_i);
    #1;
    valid_i = v; flush_i = fl; alu_ctrl_op_i = c; funct3_i = f3; funct7_i = f7; rs2_zero_i = rz;
    is_m = (c == 2'd2) && (f7 == 7'd1);
    e = '0;
    e.chk_alu = !is_m;
    e.alu = ref_alu(c, f3, f7);
    e.op = op_ref;
    if (!active) begin
      fast = 0;
`ifdef ALU_MDU_DIVZERO_FAST_EN
      fast = v && is_m && f3[2] && rz && !fl;
`endif
      if (fast) begin
        e.rsel = 1; e.divz = 1;
      end else if (v && is_m && !fl) begin
        e.start = 1; e.stall = 1;
        active = 1; t0 = cyc; lat = f3[2] ? DIV_LAT : MUL_LAT; op_ref = f3;
      end
    end else begin
      ph = cyc - t0;
      if (ph <= lat) begin
        e.stall = 1; e.busy = 1; e.abort = fl;
        if (fl) active = 0;
      end else begin
        e.rsel = !fl;
        active = 0;
      end
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'd0, 3'd0, 7'd0, 0);
  endtask

  task automatic hold(input int n, input logic [2:0] f3, input logic rz);
    for (int i = 0; i < n; i++) drive(1, 0, 2'd2, f3, 7'd1, rz);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_alu) check("alu_op", alu_op_o, e.alu);
      check("mdu_start", mdu_start_o, e.start);
      check("mdu_op", mdu_op_o, e.op);
      check("mdu_abort", mdu_abort_o, e.abort);
      check("stall", stall_o, e.stall);
      check("result_sel", result_sel_o, e.rsel);
      check("busy", busy_o, e.busy);
`ifdef ALU_MDU_DIVZERO_FAST_EN
      check("divzero", divzero_o, e.divz);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] f7;
    rst_ni = 0; valid_i = 0; flush_i = 0; alu_ctrl_op_i = 0; funct3_i = 0; funct7_i = 0;
    rs2_zero_i = 0;
    #1;
    check("rst_mdu_op", mdu_op_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_result_sel", result_sel_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_start", mdu_start_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;

    // Decode: named cases, then full sweep
    drive(1, 0, 2'd2, 3'd0, 7'h20, 0);
    drive(1, 0, 2'd2, 3'd0, 7'h00, 0);
    drive(1, 0, 2'd3, 3'd5, 7'h20, 0);
    drive(1, 0, 2'd3, 3'd0, 7'h20, 0);
    for (int c = 0; c < 4; c++)
      for (int f = 0; f < 8; f++) begin
        drive(0, 0, 2'(c), 3'(f), 7'h00, 0);
        drive(0, 0, 2'(c), 3'(f), 7'h20, 0);
      end

    // MUL, instruction held while stalled
    hold(6, 3'd0, 0);
    idle(3);

    // DIVU then back-to-back MUL at T+35
    hold(35, 3'd5, 0);
    hold(6, 3'd0, 0);
    idle(3);

    // Flush at T+2 of a DIV
    hold(2, 3'd4, 0);
    drive(1, 1, 2'd2, 3'd4, 7'd1, 0);
    idle(4);

    // REM by zero: fast path with the macro, full divide latency without
    hold(35, 3'd6, 1);
    idle(3);

    // Reset mid-BUSY at T+10
    hold(10, 3'd4, 0);
    @(posedge clk_i);
    #1;
    valid_i = 0; flush_i = 0;
    #1 check("busy_before_reset", busy_o, 1);
    #1 rst_ni = 0;
    #1;
    check("midrst_mdu_op", mdu_op_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_result_sel", result_sel_o, 0);
    check("midrst_stall", stall_o, 0);
    @(negedge clk_i);
    #1 rst_ni = 1;
    active = 0; op_ref = 3'd0;
    idle(2);

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      case ($urandom_range(3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      drive(1'($urandom_range(9) < 7), 1'($urandom_range(19) == 0),
            ($urandom_range(2) == 0) ? 2'($urandom) : 2'd2,
            3'($urandom), f7, 1'($urandom));
    end
    idle(40);

    repeat (2) @(posedge clk_i);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mdu_controller.md
Name: alu_mdu_controller

Overview:
- Successor to the single-cycle ALU decoder.
- Decodes alu_ctrl_op_i, funct3_i and funct7_i into the ALU operation code, and detects RV32M multiply/divide instructions.
- Sequences a fixed-latency iterative MDU through an IDLE/BUSY/DONE state machine, stalling the core for the configured latency.
- Sits between the main control unit and the ALU/MDU datapath, and drives the PC-hold stall and writeback result select.

Parameters:
- ALU_OP_W, 4: width of alu_op_o; must be ≥4, upper bits zero-filled.
- MUL_LATENCY, 4: MDU cycles for funct3 0–3 (MUL/MULH/MULHSU/MULHU); must be ≥1.
- DIV_LATENCY, 33: MDU cycles for funct3 4–7 (DIV/DIVU/REM/REMU); must be ≥1.

Ports:
- clk_i  input  1  core clock
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  instruction in execute is valid
- flush_i  input  1  abort any in-flight MDU op
- alu_ctrl_op_i  input  2  00=ADD, 01=SUB, 10=R-type decode, 11=I-type decode
- funct3_i  input  3  instruction funct3
- funct7_i  input  7  instruction funct7
- rs2_zero_i  input  1  divisor operand equals zero
- alu_op_o  output  ALU_OP_W  ALU operation code
- mdu_start_o  output  1  one-cycle MDU launch pulse
- mdu_op_o  output  3  latched funct3 for the MDU
- mdu_abort_o  output  1  one-cycle MDU kill pulse
- stall_o  output  1  hold PC and the execute instruction
- result_sel_o  output  1  writeback takes the MDU result
- busy_o  output  1  state is BUSY

Behaviour:
- Reset is asynchronous and active-low. It forces state=IDLE, counter=0, mdu_op_o=0, busy_o=0 and result_sel_o=0. The combinational outputs mdu_start_o, stall_o and mdu_abort_o are 0 while in IDLE with valid_i=0.
- ALU op encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - alu_ctrl_op_i 00→ADD; 01→SUB.
  - alu_ctrl_op_i 10→ decode by funct3. funct7[5]=1 selects SUB for funct3=0 and SRA for funct3=5.
  - alu_ctrl_op_i 11→ decode by funct3. funct7[5] is honoured only for funct3=5; funct3=0 is always ADD.
- is_m = (alu_ctrl_op_i==10) && (funct7_i==7'b0000001). alu_op_o remains ADD-decoded and is ignored when is_m.
- IDLE:
  - If valid_i && is_m && !flush_i, this is the issue cycle T:
    - Combinational outputs: mdu_start_o=1, stall_o=1.
    - Registered: mdu_op_o<=funct3_i; counter<=LAT-1, where LAT = funct3_i[2] ? DIV_LATENCY : MUL_LATENCY.
    - Next state: BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - Outputs: stall_o=1, busy_o=1.
  - Counter decrements each cycle. When counter==0, the next state is DONE.
  - BUSY lasts exactly LAT cycles, so stall_o is high for LAT+1 cycles in total (T..T+LAT).
- DONE:
  - Lasts one cycle, at T+LAT+1.
  - Outputs: stall_o=0, result_sel_o=1. No re-issue check is made, even though the same instruction is still presented.
  - Next state: IDLE.
- flush_i:
  - In BUSY or DONE: next state IDLE, result_sel_o never asserts, counter cleared.
  - In BUSY only: mdu_abort_o=1 combinationally for that cycle.
  - In IDLE: suppresses issue.
  - flush_i has priority over all transitions.
- Counter width is $clog2(max(MUL_LATENCY,DIV_LATENCY)+1). The counter never wraps below 0.
- valid_i deasserting during BUSY is ignored; the op completes.

Optional Feature:
- Macro: ALU_MDU_DIVZERO_FAST_EN.
- Enabled:
  - In IDLE, valid_i && is_m && funct3_i[2] && rs2_zero_i takes a fast path: no mdu_start_o, stall_o=0, result_sel_o=1 combinationally in the same cycle, state stays IDLE.
  - In this case the MDU presents its RISC-V div-by-zero constant (all-ones quotient, dividend remainder).
  - An additional output divzero_o (1 bit) is 1 in that cycle.
- Disabled: rs2_zero_i is unused, and division by zero takes the normal DIV_LATENCY path. divzero_o does not exist.

Test Plan:
- Reset mid-BUSY (DIV issued, rst_ni low at T+10) -> all registered outputs 0 asynchronously; after release, IDLE with stall_o=0.
- Base decode sweep: alu_ctrl_op_i=10, funct3=0, funct7=0x20 -> alu_op_o=1 (SUB). Same with funct7=0x00 -> 0 (ADD). alu_ctrl_op_i=11, funct3=5, funct7=0x20 -> 7 (SRA). alu_ctrl_op_i=11, funct3=0, funct7=0x20 -> 0 (ADD).
- MUL, MUL_LATENCY=4: valid_i=1, funct7=0x01, funct3=0 at T -> mdu_start_o=1 only at T; stall_o=1 T..T+4; busy_o=1 T+1..T+4; result_sel_o=1 only at T+5; mdu_op_o=0.
- DIVU, DIV_LATENCY=33: issue at T -> stall_o high 34 cycles; result_sel_o at T+34; mdu_op_o=5. Back-to-back second MUL at T+35 -> new mdu_start_o.
- Flush at T+2 of a DIV -> mdu_abort_o=1 at T+2; IDLE at T+3; no result_sel_o; stall_o=0 from T+3.
- With ALU_MDU_DIVZERO_FAST_EN: REM with rs2_zero_i=1 -> mdu_start_o=0, stall_o=0, result_sel_o=1, divzero_o=1 same cycle. Without the macro -> 34-cycle stall path.
